// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the pattern sequencer run controller.
package pattern_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESTART,
    DWELL,
    STEP,
    LOOPBACK,
    FINISH,
    ABORT
  } ctrl_state_t;

  // Sequencer step index at which the terminal output is expected high.
  localparam logic [2:0] STEP_TERMINAL    = 3'd4;
  // Step index the sequencer jumps to on goto_third.
  localparam logic [2:0] STEP_LOOP_TARGET = 3'd2;

endpackage

// File: rtl/seq_dwell_counter.sv
// Dwell down-counter: loadable, decrements without wrapping, flags zero.
module seq_dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // Load has priority over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Run controller for the 5-step pattern sequencer: dwell per step,
// terminal->third loop-backs, abort handling and desync detection.
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int LOOP_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic [LOOP_W-1:0]  cmd_loops,
  input  logic               abort,
  input  logic               seq_terminal,
  output logic               seq_restart,
  output logic               seq_pause,
  output logic               seq_goto_third,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               sync_err
);

  ctrl_state_t        state_q, state_d;
  logic [2:0]         step_idx_q, step_idx_d;
  logic [LOOP_W-1:0]  loops_left_q, loops_left_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               sync_err_q, sync_err_d;
  logic               dwell_zero;
  logic               dwell_load;
  logic               dwell_dec;

  // Every entry into DWELL (from RESTART, STEP or LOOPBACK) reloads the hold count.
  assign dwell_load = (state_q == RESTART) || (state_q == STEP) || (state_q == LOOPBACK);
  assign dwell_dec  = (state_q == DWELL);

  seq_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dwell_load),
    .dec      (dwell_dec),
    .load_val (dwell_q),
    .zero     (dwell_zero)
  );

  // Next-state logic and run bookkeeping; abort from any busy state wins.
  always_comb begin
    state_d      = state_q;
    step_idx_d   = step_idx_q;
    loops_left_d = loops_left_q;
    dwell_d      = dwell_q;
    sync_err_d   = sync_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dwell_d      = cmd_dwell;
          loops_left_d = cmd_loops;
          sync_err_d   = 1'b0;
          state_d      = RESTART;
        end
      end
      RESTART: begin
        step_idx_d = '0;
        state_d    = DWELL;
      end
      DWELL: begin
        if (seq_terminal != (step_idx_q == STEP_TERMINAL)) begin
          sync_err_d = 1'b1;
        end
        if (dwell_zero) begin
          if (step_idx_q != STEP_TERMINAL) begin
            state_d = STEP;
          end else if (loops_left_q != '0) begin
            state_d = LOOPBACK;
          end else begin
            state_d = FINISH;
          end
        end
      end
      STEP: begin
        step_idx_d = step_idx_q + 3'd1;
        state_d    = DWELL;
      end
      LOOPBACK: begin
        step_idx_d = STEP_LOOP_TARGET;
        if (loops_left_q != '0) begin
          loops_left_d = loops_left_q - LOOP_W'(1);
        end
        state_d = DWELL;
      end
      FINISH: begin
        state_d = IDLE;
      end
      ABORT: begin
        step_idx_d = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = ABORT;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_idx_q   <= '0;
      loops_left_q <= '0;
      dwell_q      <= '0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_idx_q   <= step_idx_d;
      loops_left_q <= loops_left_d;
      dwell_q      <= dwell_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Moore output decode.
  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign seq_restart    = (state_q == RESTART) || (state_q == ABORT);
  assign seq_goto_third = (state_q == LOOPBACK);
  assign seq_pause      = (state_q != STEP);
  assign done           = (state_q == FINISH);
  assign aborted        = (state_q == ABORT);
  assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Directed bench for pattern_seq_ctrl with a small sequencer stand-in
// that produces seq_terminal from the controller's outputs.
module tb_pattern_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_dwell;
  logic [3:0] cmd_loops;
  logic       abort;
  logic       seq_terminal;
  logic       seq_restart;
  logic       seq_pause;
  logic       seq_goto_third;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       sync_err;

  int errors = 0;
  int checks = 0;

  logic [2:0] seq_pos;
  logic       force_term;

  always #5 clk = ~clk;

  pattern_seq_ctrl #(
    .DWELL_W (8),
    .LOOP_W  (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_dwell      (cmd_dwell),
    .cmd_loops      (cmd_loops),
    .abort          (abort),
    .seq_terminal   (seq_terminal),
    .seq_restart    (seq_restart),
    .seq_pause      (seq_pause),
    .seq_goto_third (seq_goto_third),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .sync_err       (sync_err)
  );

  // Sequencer stand-in: restart -> 0, goto_third -> 2, unpaused advance up to 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_pos <= 3'd0;
    else if (seq_restart) seq_pos <= 3'd0;
    else if (seq_goto_third) seq_pos <= 3'd2;
    else if (!seq_pause && seq_pos < 3'd4) seq_pos <= seq_pos + 3'd1;
  end
  assign seq_terminal = force_term | (seq_pos == 3'd4);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a command so it is accepted at the next rising edge (edge 0).
  task automatic accept(input logic [7:0] d, input logic [3:0] l);
    @(negedge clk);
    cmd_dwell = d;
    cmd_loops = l;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (seq_pause !== 1'b1) begin errors++; $display("FAIL reset_pause got=%b exp=1", seq_pause); end
    checks++; if (seq_restart !== 1'b0) begin errors++; $display("FAIL reset_restart got=%b exp=0", seq_restart); end
    checks++; if (seq_goto_third !== 1'b0) begin errors++; $display("FAIL reset_goto got=%b exp=0", seq_goto_third); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (done !== 1'b0 || aborted !== 1'b0) begin errors++; $display("FAIL reset_pulses got done=%b aborted=%b exp=0,0", done, aborted); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got=%b exp=0", sync_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_pass;
    logic ep;
    accept(8'd0, 4'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      ep = !(c == 3 || c == 5 || c == 7 || c == 9);
      checks++; if (seq_pause !== ep) begin errors++; $display("FAIL single_pause cyc=%0d got=%b exp=%b", c, seq_pause, ep); end
      checks++; if (done !== (c == 11)) begin errors++; $display("FAIL single_done cyc=%0d got=%b exp=%b", c, done, (c == 11)); end
      checks++; if (cmd_ready !== (c == 12)) begin errors++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", c, cmd_ready, (c == 12)); end
      checks++; if (busy !== (c <= 11)) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy, (c <= 11)); end
    end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL single_sync_err got=%b exp=0", sync_err); end
  endtask

  task automatic test_loops;
    accept(8'd2, 4'd2);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      checks++; if (seq_goto_third !== (c == 21 || c == 33)) begin errors++; $display("FAIL loops_goto cyc=%0d got=%b exp=%b", c, seq_goto_third, (c == 21 || c == 33)); end
      checks++; if (done !== (c == 45)) begin errors++; $display("FAIL loops_done cyc=%0d got=%b exp=%b", c, done, (c == 45)); end
      checks++; if (busy !== (c <= 45)) begin errors++; $display("FAIL loops_busy cyc=%0d got=%b exp=%b", c, busy, (c <= 45)); end
    end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL loops_sync_err got=%b exp=0", sync_err); end
  endtask

  task automatic test_abort;
    accept(8'd1, 4'd0);
    @(negedge clk); // cycle 1: RESTART
    @(negedge clk); // cycle 2: DWELL
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk); // cycle 3: ABORT
    checks++; if (seq_restart !== 1'b1) begin errors++; $display("FAIL abort_restart got=%b exp=1", seq_restart); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_pulse got=%b exp=1", aborted); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    @(negedge clk); // cycle 4: IDLE
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got ready=%b busy=%b exp=1,0", cmd_ready, busy); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort_pulse_len got=%b exp=0", aborted); end
    accept(8'd0, 4'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++; if (done !== (c == 11)) begin errors++; $display("FAIL abort_rerun_done cyc=%0d got=%b exp=%b", c, done, (c == 11)); end
    end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL abort_rerun_sync got=%b exp=0", sync_err); end
  endtask

  task automatic test_sync_err;
    accept(8'd0, 4'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++; if (sync_err !== (c >= 5)) begin errors++; $display("FAIL sync_err cyc=%0d got=%b exp=%b", c, sync_err, (c >= 5)); end
      force_term = (c == 4);
    end
    force_term = 1'b0;
    accept(8'd0, 4'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_err_clear cyc=%0d got=%b exp=0", c, sync_err); end
      checks++; if (done !== (c == 11)) begin errors++; $display("FAIL sync_rerun_done cyc=%0d got=%b exp=%b", c, done, (c == 11)); end
    end
  endtask

  task automatic test_back_to_back;
    logic idle_c;
    accept(8'd0, 4'd0);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      idle_c = (c == 12 || c == 24);
      checks++; if (cmd_ready !== idle_c) begin errors++; $display("FAIL hold_ready cyc=%0d got=%b exp=%b", c, cmd_ready, idle_c); end
      checks++; if (done !== (c == 11 || c == 23)) begin errors++; $display("FAIL hold_done cyc=%0d got=%b exp=%b", c, done, (c == 11 || c == 23)); end
      if (c == 13) begin
        checks++; if (seq_restart !== 1'b1) begin errors++; $display("FAIL hold_accept got=%b exp=1", seq_restart); end
      end
      if (c == 2) cmd_valid = 1'b1;
      if (c == 13) cmd_valid = 1'b0;
    end
    // Command and abort together in IDLE: the command wins.
    @(negedge clk);
    cmd_dwell = 8'd0;
    cmd_loops = 4'd0;
    cmd_valid = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (seq_restart !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL idle_abort_accept got restart=%b busy=%b exp=1,1", seq_restart, busy); end
      end
      checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL idle_abort_pulse cyc=%0d got=%b exp=0", c, aborted); end
      checks++; if (done !== (c == 11)) begin errors++; $display("FAIL idle_abort_done cyc=%0d got=%b exp=%b", c, done, (c == 11)); end
    end
  endtask

  task automatic test_reset_mid_run;
    accept(8'd0, 4'd1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 11) begin
        checks++; if (seq_goto_third !== 1'b1) begin errors++; $display("FAIL mid_reset_loopback got=%b exp=1", seq_goto_third); end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (seq_pause !== 1'b1 || seq_goto_third !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs got pause=%b goto=%b exp=1,0", seq_pause, seq_goto_third); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_idle got busy=%b ready=%b exp=0,1", busy, cmd_ready); end
    checks++; if (done !== 1'b0 || aborted !== 1'b0 || seq_restart !== 1'b0) begin errors++; $display("FAIL mid_reset_pulses got done=%b aborted=%b restart=%b exp=0,0,0", done, aborted, seq_restart); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset cyc=%0d got done=%b aborted=%b busy=%b exp=0,0,0", c, done, aborted, busy); end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_dwell  = 8'd0;
    cmd_loops  = 4'd0;
    abort      = 1'b0;
    force_term = 1'b0;
    test_reset;
    test_single_pass;
    test_loops;
    test_abort;
    test_sync_err;
    test_back_to_back;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
